// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
// Tracker entries carry a fixed-width rd so one struct serves every REG_AW up to RD_MAX.
package fwd_pkg;

  localparam int RD_MAX = 8;

  typedef struct packed {
    logic              v;
    logic [RD_MAX-1:0] rd;
    logic              ld;
  } trk_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } fsm_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Priority matcher for one EX source against the in-flight writers.
// The youngest matching writer (smallest stage index) wins.
module fwd_match_prio
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = sel_w(DEPTH)
) (
  input  logic [REG_AW-1:0] src,
  input  trk_entry_t        trk [1:DEPTH],
  output logic [SEL_W-1:0]  sel,
  output logic              early_ld
);

  // Scanning oldest to youngest lets the youngest match overwrite the result.
  always_comb begin
    sel      = '0;
    early_ld = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (trk[k].v && (trk[k].rd == RD_MAX'(src))) begin
        sel      = SEL_W'(k);
        early_ld = trk[k].ld && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall controller for the instruction in EX.
// Tracks writers past EX, sequences load-use stalls and keeps error/perf status.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              hold,
  input  logic                              flush,
  input  logic                              ex_valid,
  input  logic [REG_AW-1:0]                 ex_rd,
  input  logic                              ex_regwrite,
  input  logic                              ex_memread,
  input  logic [NUM_SRC*REG_AW-1:0]         ex_src,
  input  logic [NUM_SRC*REG_AW-1:0]         id_src,
  output logic [NUM_SRC*sel_w(DEPTH)-1:0]   fwd_sel,
  output logic                              stall_req,
  output logic                              hazard_err,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic [CNT_W-1:0]                  fwd_cnt
);

  localparam int SEL_W     = sel_w(DEPTH);
  localparam int CW        = $clog2(LOAD_STAGE + 1);
  localparam bit CAN_STALL = (LOAD_STAGE > 1);

  trk_entry_t       trk_reg [1:DEPTH];
  fsm_t             state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             hazard_err_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] fwd_cnt_reg;
  logic [NUM_SRC-1:0] early_ld;
  logic [NUM_SRC-1:0] id_hit;
  logic             detect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) trk_reg[k] <= '0;
    end else if (!hold) begin
      trk_reg[1] <= '{v:  ex_valid & ex_regwrite & (ex_rd != '0),
                      rd: RD_MAX'(ex_rd),
                      ld: ex_memread};
      for (int k = 2; k <= DEPTH; k++) trk_reg[k] <= trk_reg[k-1];
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_match_prio #(
      .REG_AW    (REG_AW),
      .DEPTH     (DEPTH),
      .LOAD_STAGE(LOAD_STAGE),
      .SEL_W     (SEL_W)
    ) u_match (
      .src     (ex_src[gi*REG_AW +: REG_AW]),
      .trk     (trk_reg),
      .sel     (fwd_sel[gi*SEL_W +: SEL_W]),
      .early_ld(early_ld[gi])
    );
    assign id_hit[gi] = (id_src[gi*REG_AW +: REG_AW] == ex_rd);
  end

  assign detect = ex_valid & ex_memread & ex_regwrite & (ex_rd != '0) & (|id_hit) & ~flush;

  // Reset gates the request so it falls immediately, even while detect is high.
  always_comb begin
    stall_req = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE:    stall_req = detect && CAN_STALL;
        STALL:   stall_req = !flush && (hold || (cnt_reg != CW'(1)));
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Flush aborts a stall even under hold, so the request cannot reappear later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (detect && !hold && CAN_STALL) begin
            state_reg <= STALL;
            cnt_reg   <= CW'(LOAD_STAGE - 1);
          end
        end
        STALL: begin
          if (flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (!hold) begin
            if (cnt_reg == CW'(1)) state_reg <= IDLE;
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hazard_err_reg <= 1'b0;
      stall_cnt_reg  <= '0;
      fwd_cnt_reg    <= '0;
    end else begin
      hazard_err_reg <= hazard_err_reg | (|early_ld);
      if (!hold) begin
        if (stall_req && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        if ((|fwd_sel) && (fwd_cnt_reg != '1)) fwd_cnt_reg <= fwd_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign hazard_err = hazard_err_reg;
  assign stall_cnt  = stall_cnt_reg;
  assign fwd_cnt    = fwd_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two configurations (DEPTH/LOAD_STAGE 2/2 with 4-bit
// counters, 3/3 with 16-bit counters) share stimulus; directed scenarios plus a random run.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hold, flush, ex_valid, ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic [9:0] ex_src, id_src;
  logic [3:0] a_sel, b_sel;
  logic a_stall, b_stall, a_err, b_err;
  logic [3:0] a_scnt, a_fcnt;
  logic [15:0] b_scnt, b_fcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .DEPTH(2), .LOAD_STAGE(2), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_src(ex_src), .id_src(id_src),
    .fwd_sel(a_sel), .stall_req(a_stall), .hazard_err(a_err), .stall_cnt(a_scnt), .fwd_cnt(a_fcnt));

  fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_STAGE(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_src(ex_src), .id_src(id_src),
    .fwd_sel(b_sel), .stall_req(b_stall), .hazard_err(b_err), .stall_cnt(b_scnt), .fwd_cnt(b_fcnt));

  // Reference model: config 0 = dut_a, config 1 = dut_b.
  int cfg_d[2] = '{2, 3};
  int cfg_l[2] = '{2, 3};
  int cfg_m[2] = '{15, 65535};
  int mv[2][4];
  int mrd[2][4];
  int mld[2][4];
  bit mst[2];
  int mown[2];
  int mscnt[2];
  int mfcnt[2];
  bit merr[2];
  int esel[2][2];
  bit estall[2];
  bit eerrset[2];
  bit mdet;

  function void m_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        mv[c][k] = 0; mrd[c][k] = 0; mld[c][k] = 0;
      end
      mst[c] = 0; mown[c] = 0; mscnt[c] = 0; mfcnt[c] = 0; merr[c] = 0;
    end
  endfunction

  function void m_eval();
    int s;
    mdet = ex_valid && ex_memread && ex_regwrite && (ex_rd != 0) &&
           ((id_src[4:0] == ex_rd) || (id_src[9:5] == ex_rd)) && !flush;
    for (int c = 0; c < 2; c++) begin
      eerrset[c] = 0;
      for (int i = 0; i < 2; i++) begin
        s = (i == 0) ? int'(ex_src[4:0]) : int'(ex_src[9:5]);
        esel[c][i] = 0;
        for (int k = 1; k <= cfg_d[c]; k++)
          if (esel[c][i] == 0 && mv[c][k] != 0 && mrd[c][k] == s) esel[c][i] = k;
        if (esel[c][i] != 0 && esel[c][i] < cfg_l[c] && mld[c][esel[c][i]] != 0) eerrset[c] = 1;
      end
      if (reset) estall[c] = 0;
      else if (!mst[c]) estall[c] = mdet && (cfg_l[c] > 1);
      else if (flush) estall[c] = 0;
      else if (hold) estall[c] = 1;
      else estall[c] = (mown[c] > 0);
    end
  endfunction

  function void m_tick();
    if (reset) return;
    for (int c = 0; c < 2; c++) begin
      merr[c] = merr[c] | eerrset[c];
      if (mst[c] && flush) mst[c] = 0;
      else if (!hold) begin
        if (!mst[c]) begin
          if (mdet && cfg_l[c] > 1) begin mst[c] = 1; mown[c] = cfg_l[c] - 2; end
        end else if (mown[c] > 0) mown[c]--;
        else mst[c] = 0;
      end
      if (!hold) begin
        if (estall[c] && mscnt[c] < cfg_m[c]) mscnt[c]++;
        if ((esel[c][0] != 0 || esel[c][1] != 0) && mfcnt[c] < cfg_m[c]) mfcnt[c]++;
        for (int k = cfg_d[c]; k >= 2; k--) begin
          mv[c][k] = mv[c][k-1]; mrd[c][k] = mrd[c][k-1]; mld[c][k] = mld[c][k-1];
        end
        mv[c][1] = ex_valid && ex_regwrite && (ex_rd != 0);
        mrd[c][1] = ex_rd;
        mld[c][1] = ex_memread;
      end
    end
  endfunction

  task automatic idle_in();
    hold = 0; flush = 0; ex_valid = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    ex_src = 0; id_src = 0;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] s0, input logic [4:0] s1);
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr; ex_src = {s1, s0};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle_in(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle_in(); reset = 1;
    set_ex(1, 5'd5, 1, 1, 5'd0, 5'd0); id_src = {5'd0, 5'd5};
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_a got=%b want=0", a_stall); end
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_b got=%b want=0", b_stall); end
    checks++; if (a_sel !== 4'd0) begin errors++; $display("FAIL reset_sel_a got=%h want=0", a_sel); end
    checks++; if ({a_err, a_scnt, a_fcnt} !== 9'd0) begin errors++; $display("FAIL reset_status_a got=%h want=0", {a_err, a_scnt, a_fcnt}); end
    checks++; if ({b_err, b_scnt, b_fcnt} !== 33'd0) begin errors++; $display("FAIL reset_status_b got=%h want=0", {b_err, b_scnt, b_fcnt}); end
    @(posedge clk); #1; reset = 0; idle_in();
    $display("test_reset done");
  endtask

  task automatic test_forward();
    apply_reset();
    set_ex(1, 5'd3, 1, 0, 5'd0, 5'd0); tick();
    set_ex(0, 5'd0, 0, 0, 5'd3, 5'd0); #1;
    checks++; if (a_sel[1:0] !== 2'd1) begin errors++; $display("FAIL fwd_stage1_a got=%0d want=1", a_sel[1:0]); end
    checks++; if (b_sel[1:0] !== 2'd1) begin errors++; $display("FAIL fwd_stage1_b got=%0d want=1", b_sel[1:0]); end
    tick(); #1;
    checks++; if (a_sel[1:0] !== 2'd2) begin errors++; $display("FAIL fwd_stage2_a got=%0d want=2", a_sel[1:0]); end
    checks++; if (b_sel[1:0] !== 2'd2) begin errors++; $display("FAIL fwd_stage2_b got=%0d want=2", b_sel[1:0]); end
    tick(); #1;
    checks++; if (a_sel[1:0] !== 2'd0) begin errors++; $display("FAIL fwd_expired_a got=%0d want=0", a_sel[1:0]); end
    checks++; if (b_sel[1:0] !== 2'd3) begin errors++; $display("FAIL fwd_stage3_b got=%0d want=3", b_sel[1:0]); end
    checks++; if (a_fcnt !== 4'd2) begin errors++; $display("FAIL fwd_cnt_a got=%0d want=2", a_fcnt); end
    idle_in(); tick();
    $display("test_forward done");
  endtask

  task automatic test_youngest();
    apply_reset();
    set_ex(1, 5'd3, 1, 0, 5'd0, 5'd0); tick();
    set_ex(1, 5'd3, 1, 0, 5'd0, 5'd0); tick();
    set_ex(1, 5'd0, 1, 0, 5'd0, 5'd3); #1;
    checks++; if (a_sel[3:2] !== 2'd1) begin errors++; $display("FAIL youngest_a got=%0d want=1", a_sel[3:2]); end
    checks++; if (b_sel[3:2] !== 2'd1) begin errors++; $display("FAIL youngest_b got=%0d want=1", b_sel[3:2]); end
    tick();
    set_ex(0, 5'd0, 0, 0, 5'd0, 5'd3); #1;
    checks++; if (a_sel !== 4'b1000) begin errors++; $display("FAIL r0_skip_a got=%h want=8", a_sel); end
    checks++; if (b_sel !== 4'b1000) begin errors++; $display("FAIL r0_skip_b got=%h want=8", b_sel); end
    idle_in(); tick();
    $display("test_youngest done");
  endtask

  task automatic test_load_use();
    apply_reset();
    set_ex(1, 5'd5, 1, 1, 5'd0, 5'd0); id_src = {5'd0, 5'd5}; #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_detect_a got=%b want=1", a_stall); end
    checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL lu_detect_b got=%b want=1", b_stall); end
    tick();
    set_ex(0, 5'd0, 0, 0, 5'd0, 5'd0); #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_end_a got=%b want=0", a_stall); end
    checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL lu_second_b got=%b want=1", b_stall); end
    tick();
    set_ex(0, 5'd0, 0, 0, 5'd5, 5'd0); #1;
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL lu_end_b got=%b want=0", b_stall); end
    checks++; if (a_sel[1:0] !== 2'd2) begin errors++; $display("FAIL lu_fwd_a got=%0d want=2", a_sel[1:0]); end
    tick(); idle_in(); #1;
    checks++; if (a_scnt !== 4'd1) begin errors++; $display("FAIL lu_cnt_a got=%0d want=1", a_scnt); end
    checks++; if (b_scnt !== 16'd2) begin errors++; $display("FAIL lu_cnt_b got=%0d want=2", b_scnt); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL lu_noerr_a got=%b want=0", a_err); end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_hold();
    apply_reset();
    set_ex(1, 5'd5, 1, 1, 5'd0, 5'd0); id_src = {5'd0, 5'd5}; tick();
    set_ex(0, 5'd0, 0, 0, 5'd0, 5'd0); hold = 1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if ({a_stall, b_stall} !== 2'b11) begin errors++; $display("FAIL hold_stall[%0d] got=%b want=11", n, {a_stall, b_stall}); end
      checks++; if (a_scnt !== 4'd1) begin errors++; $display("FAIL hold_cnt_a[%0d] got=%0d want=1", n, a_scnt); end
      tick();
    end
    hold = 0; #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL hold_resume_a got=%b want=0", a_stall); end
    checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL hold_resume_b got=%b want=1", b_stall); end
    tick(); #1;
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL hold_end_b got=%b want=0", b_stall); end
    checks++; if (b_scnt !== 16'd2) begin errors++; $display("FAIL hold_cnt_b got=%0d want=2", b_scnt); end
    idle_in(); tick();
    $display("test_hold done");
  endtask

  task automatic test_flush();
    apply_reset();
    set_ex(1, 5'd5, 1, 1, 5'd0, 5'd0); id_src = {5'd0, 5'd5}; flush = 1; #1;
    checks++; if ({a_stall, b_stall} !== 2'b00) begin errors++; $display("FAIL flush_detect got=%b want=00", {a_stall, b_stall}); end
    tick(); idle_in(); #1;
    checks++; if ({a_stall, b_stall} !== 2'b00) begin errors++; $display("FAIL flush_idle got=%b want=00", {a_stall, b_stall}); end
    tick();
    set_ex(1, 5'd6, 1, 1, 5'd0, 5'd0); id_src = {5'd6, 5'd0}; tick();
    idle_in(); flush = 1; #1;
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL flush_stall_b got=%b want=0", b_stall); end
    tick(); flush = 0; #1;
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL flush_back_idle_b got=%b want=0", b_stall); end
    tick();
    set_ex(1, 5'd7, 1, 1, 5'd0, 5'd0); id_src = {5'd7, 5'd0}; tick();
    idle_in(); #1;
    checks++; if ({b_stall, b_scnt} !== {1'b1, 16'd2}) begin errors++; $display("FAIL pre_areset_b got=%b/%0d want=1/2", b_stall, b_scnt); end
    reset = 1; #1;
    checks++; if ({b_stall, b_scnt, b_sel} !== 21'd0) begin errors++; $display("FAIL areset_b got=%h want=0", {b_stall, b_scnt, b_sel}); end
    checks++; if ({a_stall, a_scnt, a_sel} !== 9'd0) begin errors++; $display("FAIL areset_a got=%h want=0", {a_stall, a_scnt, a_sel}); end
    tick(); reset = 0; tick();
    $display("test_flush done");
  endtask

  task automatic test_hazard_err();
    apply_reset();
    set_ex(1, 5'd5, 1, 1, 5'd0, 5'd0); tick();
    set_ex(1, 5'd9, 1, 0, 5'd5, 5'd0); #1;
    checks++; if (a_sel[1:0] !== 2'd1) begin errors++; $display("FAIL err_fwd_a got=%0d want=1", a_sel[1:0]); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_early_a got=%b want=0", a_err); end
    tick(); idle_in();
    for (int n = 0; n < 4; n++) tick();
    #1;
    checks++; if ({a_err, b_err} !== 2'b11) begin errors++; $display("FAIL err_sticky got=%b want=11", {a_err, b_err}); end
    apply_reset(); #1;
    checks++; if ({a_err, b_err} !== 2'b00) begin errors++; $display("FAIL err_clear got=%b want=00", {a_err, b_err}); end
    $display("test_hazard_err done");
  endtask

  task automatic test_fwd_sat();
    apply_reset();
    set_ex(1, 5'd3, 1, 0, 5'd3, 5'd0);
    for (int n = 0; n < 21; n++) tick();
    idle_in(); #1;
    checks++; if (a_fcnt !== 4'd15) begin errors++; $display("FAIL fwd_sat_a got=%0d want=15", a_fcnt); end
    checks++; if (b_fcnt !== 16'd20) begin errors++; $display("FAIL fwd_nosat_b got=%0d want=20", b_fcnt); end
    tick();
    $display("test_fwd_sat done");
  endtask

  task automatic test_random();
    logic [3:0] gsel;
    logic gst, gerr;
    int gscnt, gfcnt;
    int err0;
    err0 = errors;
    apply_reset(); m_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      hold = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_rd = 5'($urandom_range(0, 3));
      ex_regwrite = ($urandom_range(0, 4) != 0);
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_src = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      if (reset) m_reset();
      @(negedge clk);
      m_eval();
      for (int c = 0; c < 2; c++) begin
        gsel = (c == 0) ? a_sel : b_sel;
        gst = (c == 0) ? a_stall : b_stall;
        gerr = (c == 0) ? a_err : b_err;
        gscnt = (c == 0) ? int'(a_scnt) : int'(b_scnt);
        gfcnt = (c == 0) ? int'(a_fcnt) : int'(b_fcnt);
        checks++; if (gsel !== {2'(esel[c][1]), 2'(esel[c][0])}) begin errors++; $display("FAIL rnd_sel cfg%0d cyc%0d got=%h want=%0d/%0d", c, n, gsel, esel[c][1], esel[c][0]); end
        checks++; if (gst !== estall[c]) begin errors++; $display("FAIL rnd_stall cfg%0d cyc%0d got=%b want=%b", c, n, gst, estall[c]); end
        checks++; if (gerr !== merr[c]) begin errors++; $display("FAIL rnd_err cfg%0d cyc%0d got=%b want=%b", c, n, gerr, merr[c]); end
        checks++; if (gscnt != mscnt[c]) begin errors++; $display("FAIL rnd_scnt cfg%0d cyc%0d got=%0d want=%0d", c, n, gscnt, mscnt[c]); end
        checks++; if (gfcnt != mfcnt[c]) begin errors++; $display("FAIL rnd_fcnt cfg%0d cyc%0d got=%0d want=%0d", c, n, gfcnt, mfcnt[c]); end
      end
      @(posedge clk);
      m_tick();
      #1;
    end
    reset = 0; idle_in(); tick();
    $display("test_random done: %0d new errors", errors - err0);
  endtask

  initial begin
    idle_in();
    test_reset();
    test_forward();
    test_youngest();
    test_load_use();
    test_hold();
    test_flush();
    test_hazard_err();
    test_fwd_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
